// File: rtl/sys_arr_skew_feeder.sv
// Skew feeder for the DSP systolic array.
// Accepts one N-row vector of single_float operands per handshake and emits
// each row as a float_reg {data, dirty}. Row i is delayed by i enabled cycles
// so that the operands enter the array on its diagonal wavefront. After the
// final vector of a stream the pipeline drains with bubbles, then done pulses.
module sys_arr_skew_feeder #(
    parameter int N      = 4,
    parameter int WORD_W = 32,   // must match the single_float width
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N*WORD_W-1:0]     in_data,
    input  logic                    in_last,
    input  logic                    arr_en,
    output logic [N*(WORD_W+1)-1:0] row_out,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_W-1:0]        vec_cnt
);

    localparam int RW = WORD_W + 1;
    localparam int DW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [DW-1:0]   drain_cnt;
    logic [DW-1:0]   drain_next;
    logic            xfer;

    // Upstream may only hand over a vector while the array advances and we
    // are not draining; held low while reset is asserted.
    assign in_ready = arr_en && !rst && (state == ST_IDLE || state == ST_STREAM);
    assign xfer     = in_valid && in_ready;
    assign busy     = (state == ST_STREAM) || (state == ST_DRAIN);
    assign done     = (state == ST_DONE);

    // Next-state logic: the drain counter counts the enabled cycles needed for
    // the last vector's top row to reach the output; DONE always lasts one cycle.
    always_comb begin
        state_next = state;
        drain_next = drain_cnt;
        case (state)
            ST_IDLE, ST_STREAM: begin
                if (xfer) begin
                    if (in_last) begin
                        if (N == 1) begin
                            state_next = ST_DONE;
                        end else begin
                            state_next = ST_DRAIN;
                            drain_next = DW'(N - 1);
                        end
                    end else begin
                        state_next = ST_STREAM;
                    end
                end
            end
            ST_DRAIN: begin
                if (arr_en) begin
                    drain_next = drain_cnt - 1'b1;
                    if (drain_cnt == DW'(1)) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and drain counter registers; hold behaviour is encoded in next-state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            drain_cnt <= '0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_next;
        end
    end

    // Saturating count of vectors accepted in this stream, cleared leaving DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_cnt <= '0;
        end else if (state == ST_DONE) begin
            vec_cnt <= '0;
        end else if (xfer && (vec_cnt != {CNT_W{1'b1}})) begin
            vec_cnt <= vec_cnt + 1'b1;
        end
    end

    // One delay chain per row, row r being r+1 registers deep.
    for (genvar r = 0; r < N; r++) begin : g_row
        logic [RW-1:0] chain [0:r];

        // Stage 0 takes the operand on a handshake or a bubble otherwise;
        // later stages shift only when the array advances.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int j = 0; j <= r; j++) begin
                    chain[j] <= '0;
                end
            end else if (arr_en) begin
                chain[0] <= xfer ? {in_data[r*WORD_W +: WORD_W], 1'b1} : '0;
                for (int j = 1; j <= r; j++) begin
                    chain[j] <= chain[j-1];
                end
            end
        end

        assign row_out[r*RW +: RW] = chain[r];
    end

endmodule

// File: tb/tb_sys_arr_skew_feeder.sv
// Testbench for sys_arr_skew_feeder: an N=4 instance checked against a
// stream-level reference model, plus an N=1 instance with a narrow counter.
module tb_sys_arr_skew_feeder;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int CW = 16;
    localparam int RW = W + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [N*W-1:0]    in_data;
    logic              in_last;
    logic              arr_en;
    logic [N*RW-1:0]   row_out;
    logic              busy;
    logic              done;
    logic [CW-1:0]     vec_cnt;

    logic              v1;
    logic              l1;
    logic              e1;
    logic [W-1:0]      d1;
    logic              ready1;
    logic              busy1;
    logic              done1;
    logic [RW-1:0]     r1;
    logic [1:0]        cnt1;

    int total = 0;
    int bad   = 0;

    sys_arr_skew_feeder #(.N(N), .WORD_W(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .arr_en(arr_en),
        .row_out(row_out), .busy(busy), .done(done), .vec_cnt(vec_cnt)
    );

    sys_arr_skew_feeder #(.N(1), .WORD_W(W), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(ready1),
        .in_data(d1), .in_last(l1), .arr_en(e1),
        .row_out(r1), .busy(busy1), .done(done1), .vec_cnt(cnt1)
    );

    always #5 clk = ~clk;

    // Reference model: time is counted in enabled edges. The vector accepted at
    // enabled edge s is visible on row i after enabled edge s+i.
    typedef enum int {M_IDLE, M_STREAM, M_DRAIN, M_DONE} m_phase_t;
    m_phase_t       m_phase;
    int             m_t;
    int             m_end;
    int             m_cnt;
    logic [N*W-1:0] m_vec [0:4095];
    bit             m_has [0:4095];
    bit             m_ready_exp;
    bit             m_last_hs;
    logic           obs_ready;
    logic           obs_busy;

    function automatic logic [N*RW-1:0] exp_rows();
        logic [N*RW-1:0] r;
        int s;
        r = '0;
        for (int i = 0; i < N; i++) begin
            s = m_t - i;
            if (s >= 1 && m_has[s]) r[i*RW +: RW] = {m_vec[s][i*W +: W], 1'b1};
        end
        return r;
    endfunction

    task automatic model_reset();
        m_phase = M_IDLE;
        m_t     = 0;
        m_end   = 0;
        m_cnt   = 0;
        for (int i = 0; i < 4096; i++) m_has[i] = 1'b0;
    endtask

    // Drive one clock cycle on the N=4 instance and advance the model.
    task automatic cycle(input bit v, input logic [N*W-1:0] d, input bit l, input bit e);
        bit hs;
        in_valid = v;
        in_data  = d;
        in_last  = l;
        arr_en   = e;
        #1;
        m_ready_exp = e && (m_phase == M_IDLE || m_phase == M_STREAM);
        obs_ready   = in_ready;
        obs_busy    = busy;
        hs          = v && m_ready_exp;
        m_last_hs   = hs;
        @(posedge clk);
        if (e) begin
            m_t++;
            m_has[m_t] = hs;
            m_vec[m_t] = d;
        end
        if (m_phase == M_DONE) begin
            m_phase = M_IDLE;
            m_cnt   = 0;
        end else if (hs) begin
            if (m_cnt < (1 << CW) - 1) m_cnt++;
            if (l) begin
                m_end   = m_t + N - 1;
                m_phase = (N == 1) ? M_DONE : M_DRAIN;
            end else begin
                m_phase = M_STREAM;
            end
        end else if (e && m_phase == M_DRAIN && m_t == m_end) begin
            m_phase = M_DONE;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; arr_en = 1'b1;
        v1 = 1'b0; l1 = 1'b0; e1 = 1'b0; d1 = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total += 5;
        if (row_out !== '0) begin bad++; $display("[TB] FAIL reset row_out got=%h want=0", row_out); end
        if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset in_ready got=%b want=0", in_ready); end
        if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset busy got=%b want=0", busy); end
        if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset done got=%b want=0", done); end
        if (vec_cnt !== '0) begin bad++; $display("[TB] FAIL reset vec_cnt got=%0d want=0", vec_cnt); end
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL idle in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_single_vector();
        logic [N*W-1:0] vec;
        vec = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
        for (int c = 0; c < 6; c++) begin
            cycle(c == 0, (c == 0) ? vec : '0, c == 0, 1'b1);
            total += 5;
            if (row_out !== exp_rows()) begin bad++; $display("[TB] FAIL single rows c=%0d got=%h want=%h", c, row_out, exp_rows()); end
            if (obs_ready !== m_ready_exp) begin bad++; $display("[TB] FAIL single in_ready c=%0d got=%b want=%b", c, obs_ready, m_ready_exp); end
            if (busy !== (m_phase == M_STREAM || m_phase == M_DRAIN)) begin bad++; $display("[TB] FAIL single busy c=%0d got=%b", c, busy); end
            if (done !== (m_phase == M_DONE)) begin bad++; $display("[TB] FAIL single done c=%0d got=%b", c, done); end
            if (vec_cnt !== CW'(m_cnt)) begin bad++; $display("[TB] FAIL single vec_cnt c=%0d got=%0d want=%0d", c, vec_cnt, m_cnt); end
            if (c == 3) begin
                total++;
                if (row_out[3*RW +: RW] !== {32'h40800000, 1'b1} || done !== 1'b1 || vec_cnt !== CW'(1)) begin
                    bad++; $display("[TB] FAIL single row3_done got=%h/%b/%0d want=%h/1/1", row_out[3*RW +: RW], done, vec_cnt, {32'h40800000, 1'b1});
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [N*W-1:0] vecs [0:4];
        logic [W-1:0]   got  [0:N-1][0:7];
        int             gcnt [0:N-1];
        int             drain_low;
        int             cnt_at_done;
        for (int k = 0; k < 5; k++) vecs[k] = {$urandom, $urandom, $urandom, $urandom};
        vecs[2] = {32'hFF800000, 32'h00000001, 32'h7F800000, 32'h7FC00001};
        for (int i = 0; i < N; i++) gcnt[i] = 0;
        drain_low   = 0;
        cnt_at_done = -1;
        for (int c = 0; c < 12; c++) begin
            cycle(c < 5, (c < 5) ? vecs[c] : '0, c == 4, 1'b1);
            if (obs_ready === 1'b0 && obs_busy === 1'b1) drain_low++;
            if (done === 1'b1) cnt_at_done = int'(vec_cnt);
            for (int i = 0; i < N; i++) begin
                if (row_out[i*RW] === 1'b1 && gcnt[i] < 8) begin
                    got[i][gcnt[i]] = row_out[i*RW+1 +: W];
                    gcnt[i]++;
                end
            end
            total += 5;
            if (row_out !== exp_rows()) begin bad++; $display("[TB] FAIL b2b rows c=%0d got=%h want=%h", c, row_out, exp_rows()); end
            if (obs_ready !== m_ready_exp) begin bad++; $display("[TB] FAIL b2b in_ready c=%0d got=%b want=%b", c, obs_ready, m_ready_exp); end
            if (busy !== (m_phase == M_STREAM || m_phase == M_DRAIN)) begin bad++; $display("[TB] FAIL b2b busy c=%0d got=%b", c, busy); end
            if (done !== (m_phase == M_DONE)) begin bad++; $display("[TB] FAIL b2b done c=%0d got=%b", c, done); end
            if (vec_cnt !== CW'(m_cnt)) begin bad++; $display("[TB] FAIL b2b vec_cnt c=%0d got=%0d want=%0d", c, vec_cnt, m_cnt); end
        end
        total += 3;
        if (drain_low != 3) begin bad++; $display("[TB] FAIL b2b drain_ready_low got=%0d want=3", drain_low); end
        if (cnt_at_done != 5) begin bad++; $display("[TB] FAIL b2b vec_cnt_done got=%0d want=5", cnt_at_done); end
        if (vec_cnt !== '0) begin bad++; $display("[TB] FAIL b2b vec_cnt_after got=%0d want=0", vec_cnt); end
        for (int i = 0; i < N; i++) begin
            total++;
            if (gcnt[i] != 5) begin
                bad++; $display("[TB] FAIL b2b row%0d_count got=%0d want=5", i, gcnt[i]);
            end else begin
                for (int k = 0; k < 5; k++) begin
                    total++;
                    if (got[i][k] !== vecs[k][i*W +: W]) begin bad++; $display("[TB] FAIL b2b row%0d_word%0d got=%h want=%h", i, k, got[i][k], vecs[k][i*W +: W]); end
                end
            end
        end
    endtask

    // Uninterrupted, three vectors finish with done after cycle 5; a single
    // 1,0,0,1 enable pattern in STREAM or in DRAIN moves that to cycle 7.
    task automatic test_arr_en_toggle();
        logic [0:9]     vpat [0:1];
        logic [0:9]     lpat [0:1];
        logic [0:9]     epat [0:1];
        logic [N*W-1:0] vecs [0:2];
        int             sent;
        int             done_at;
        int             dcount [0:N-1];
        vpat[0] = 10'b1111100000; lpat[0] = 10'b0000100000; epat[0] = 10'b1001111111;
        vpat[1] = 10'b1110000000; lpat[1] = 10'b0010000000; epat[1] = 10'b1111001111;
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < 3; k++) vecs[k] = {$urandom, $urandom, $urandom, $urandom};
            sent    = 0;
            done_at = -1;
            for (int i = 0; i < N; i++) dcount[i] = 0;
            for (int c = 0; c < 10; c++) begin
                cycle(vpat[s][c], vecs[(sent < 3) ? sent : 2], lpat[s][c], epat[s][c]);
                if (m_last_hs) sent++;
                if (done === 1'b1 && done_at < 0) done_at = c;
                if (epat[s][c]) for (int i = 0; i < N; i++) if (row_out[i*RW] === 1'b1) dcount[i]++;
                total += 5;
                if (row_out !== exp_rows()) begin bad++; $display("[TB] FAIL toggle rows s=%0d c=%0d got=%h want=%h", s, c, row_out, exp_rows()); end
                if (obs_ready !== m_ready_exp) begin bad++; $display("[TB] FAIL toggle in_ready s=%0d c=%0d got=%b want=%b", s, c, obs_ready, m_ready_exp); end
                if (busy !== (m_phase == M_STREAM || m_phase == M_DRAIN)) begin bad++; $display("[TB] FAIL toggle busy s=%0d c=%0d got=%b", s, c, busy); end
                if (done !== (m_phase == M_DONE)) begin bad++; $display("[TB] FAIL toggle done s=%0d c=%0d got=%b", s, c, done); end
                if (vec_cnt !== CW'(m_cnt)) begin bad++; $display("[TB] FAIL toggle vec_cnt s=%0d c=%0d got=%0d want=%0d", s, c, vec_cnt, m_cnt); end
            end
            total++;
            if (done_at != 7) begin bad++; $display("[TB] FAIL toggle done_cycle s=%0d got=%0d want=7", s, done_at); end
            for (int i = 0; i < N; i++) begin
                total++;
                if (dcount[i] != 3) begin bad++; $display("[TB] FAIL toggle row%0d_dirty s=%0d got=%0d want=3", i, s, dcount[i]); end
            end
        end
    endtask

    task automatic test_valid_through_drain();
        logic [N*W-1:0] vecs [0:2];
        int             sent;
        int             first_ready;
        for (int k = 0; k < 3; k++) vecs[k] = {$urandom, $urandom, $urandom, $urandom};
        sent        = 0;
        first_ready = -1;
        for (int c = 0; c < 14; c++) begin
            cycle(sent < 3, vecs[(sent < 3) ? sent : 2], sent != 1, 1'b1);
            if (c > 0 && obs_ready === 1'b1 && first_ready < 0) first_ready = c;
            if (m_last_hs) begin
                sent++;
                if (sent == 2) begin
                    total++;
                    if (vec_cnt !== CW'(1) || busy !== 1'b1) begin bad++; $display("[TB] FAIL hold new_stream got=%0d/%b want=1/1", vec_cnt, busy); end
                end
            end
            total += 5;
            if (row_out !== exp_rows()) begin bad++; $display("[TB] FAIL hold rows c=%0d got=%h want=%h", c, row_out, exp_rows()); end
            if (obs_ready !== m_ready_exp) begin bad++; $display("[TB] FAIL hold in_ready c=%0d got=%b want=%b", c, obs_ready, m_ready_exp); end
            if (busy !== (m_phase == M_STREAM || m_phase == M_DRAIN)) begin bad++; $display("[TB] FAIL hold busy c=%0d got=%b", c, busy); end
            if (done !== (m_phase == M_DONE)) begin bad++; $display("[TB] FAIL hold done c=%0d got=%b", c, done); end
            if (vec_cnt !== CW'(m_cnt)) begin bad++; $display("[TB] FAIL hold vec_cnt c=%0d got=%0d want=%0d", c, vec_cnt, m_cnt); end
        end
        total++;
        if (first_ready != 5) begin bad++; $display("[TB] FAIL hold first_accept got=%0d want=5", first_ready); end
    endtask

    task automatic test_async_reset();
        logic [N*W-1:0] vec;
        cycle(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b1);
        cycle(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b1);
        total++;
        if ({row_out[3*RW], row_out[2*RW], row_out[RW], row_out[0], busy} !== 5'b00111) begin
            bad++; $display("[TB] FAIL arst pre_dirty got=%b want=00111", {row_out[3*RW], row_out[2*RW], row_out[RW], row_out[0], busy});
        end
        #2 rst = 1'b1;
        #1;
        total += 5;
        if (row_out !== '0) begin bad++; $display("[TB] FAIL arst row_out got=%h want=0", row_out); end
        if (busy !== 1'b0) begin bad++; $display("[TB] FAIL arst busy got=%b want=0", busy); end
        if (done !== 1'b0) begin bad++; $display("[TB] FAIL arst done got=%b want=0", done); end
        if (vec_cnt !== '0) begin bad++; $display("[TB] FAIL arst vec_cnt got=%0d want=0", vec_cnt); end
        if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL arst in_ready got=%b want=0", in_ready); end
        #1 rst = 1'b0;
        model_reset();
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL arst idle_ready got=%b want=1", in_ready); end
        vec = {$urandom, $urandom, $urandom, $urandom};
        for (int c = 0; c < 6; c++) begin
            cycle(c == 0, vec, 1'b1, 1'b1);
            total += 5;
            if (row_out !== exp_rows()) begin bad++; $display("[TB] FAIL arst rows c=%0d got=%h want=%h", c, row_out, exp_rows()); end
            if (obs_ready !== m_ready_exp) begin bad++; $display("[TB] FAIL arst in_ready c=%0d got=%b want=%b", c, obs_ready, m_ready_exp); end
            if (busy !== (m_phase == M_STREAM || m_phase == M_DRAIN)) begin bad++; $display("[TB] FAIL arst busy c=%0d got=%b", c, busy); end
            if (done !== (m_phase == M_DONE)) begin bad++; $display("[TB] FAIL arst done c=%0d got=%b", c, done); end
            if (vec_cnt !== CW'(m_cnt)) begin bad++; $display("[TB] FAIL arst vec_cnt c=%0d got=%0d want=%0d", c, vec_cnt, m_cnt); end
        end
    endtask

    task automatic test_random();
        logic [W-1:0]   specials [0:3];
        logic [N*W-1:0] d;
        specials[0] = 32'h7FC00000; specials[1] = 32'hFF800000;
        specials[2] = 32'h00000003; specials[3] = 32'h80000000;
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++) d[i*W +: W] = ($urandom_range(0, 4) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
            cycle($urandom_range(0, 3) != 0, d, $urandom_range(0, 5) == 0, $urandom_range(0, 7) != 0);
            total += 5;
            if (row_out !== exp_rows()) begin bad++; $display("[TB] FAIL rand rows c=%0d got=%h want=%h", c, row_out, exp_rows()); end
            if (obs_ready !== m_ready_exp) begin bad++; $display("[TB] FAIL rand in_ready c=%0d got=%b want=%b", c, obs_ready, m_ready_exp); end
            if (busy !== (m_phase == M_STREAM || m_phase == M_DRAIN)) begin bad++; $display("[TB] FAIL rand busy c=%0d got=%b", c, busy); end
            if (done !== (m_phase == M_DONE)) begin bad++; $display("[TB] FAIL rand done c=%0d got=%b", c, done); end
            if (vec_cnt !== CW'(m_cnt)) begin bad++; $display("[TB] FAIL rand vec_cnt c=%0d got=%0d want=%0d", c, vec_cnt, m_cnt); end
        end
    endtask

    // N=1 goes straight to DONE; its 2-bit counter saturates at 3.
    task automatic test_n1_config();
        int sat;
        e1 = 1'b1; v1 = 1'b1; l1 = 1'b1; d1 = 32'h7F800001;
        #1;
        total++;
        if (ready1 !== 1'b1) begin bad++; $display("[TB] FAIL n1 ready got=%b want=1", ready1); end
        @(posedge clk); #1;
        v1 = 1'b0;
        total += 4;
        if (r1 !== {32'h7F800001, 1'b1}) begin bad++; $display("[TB] FAIL n1 row got=%h want=%h", r1, {32'h7F800001, 1'b1}); end
        if (done1 !== 1'b1) begin bad++; $display("[TB] FAIL n1 done got=%b want=1", done1); end
        if (busy1 !== 1'b0) begin bad++; $display("[TB] FAIL n1 busy got=%b want=0", busy1); end
        if (cnt1 !== 2'd1) begin bad++; $display("[TB] FAIL n1 vec_cnt got=%0d want=1", cnt1); end
        @(posedge clk); #1;
        total += 3;
        if (done1 !== 1'b0) begin bad++; $display("[TB] FAIL n1 done_once got=%b want=0", done1); end
        if (r1 !== '0) begin bad++; $display("[TB] FAIL n1 bubble got=%h want=0", r1); end
        if (cnt1 !== 2'd0) begin bad++; $display("[TB] FAIL n1 cnt_clear got=%0d want=0", cnt1); end
        for (int k = 1; k <= 5; k++) begin
            v1 = 1'b1; l1 = (k == 5); d1 = $urandom;
            @(posedge clk); #1;
            sat = (k < 3) ? k : 3;
            total += 3;
            if (cnt1 !== 2'(sat)) begin bad++; $display("[TB] FAIL n1 sat k=%0d got=%0d want=%0d", k, cnt1, sat); end
            if (r1 !== {d1, 1'b1}) begin bad++; $display("[TB] FAIL n1 srow k=%0d got=%h want=%h", k, r1, {d1, 1'b1}); end
            if (done1 !== (k == 5)) begin bad++; $display("[TB] FAIL n1 sdone k=%0d got=%b", k, done1); end
        end
        v1 = 1'b0;
        @(posedge clk); #1;
        total++;
        if (cnt1 !== 2'd0 || done1 !== 1'b0) begin bad++; $display("[TB] FAIL n1 end got=%0d/%b want=0/0", cnt1, done1); end
    endtask

    // Run every scenario in order and report.
    initial begin
        test_reset();
        test_single_vector();
        test_back_to_back();
        test_arr_en_toggle();
        test_valid_through_drain();
        test_async_reset();
        test_random();
        test_n1_config();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Guard against a run that never reaches the summary.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

endmodule
